// File: rtl/wb_update.sv
// wb_update: live weight/bias store and batch sequencer downstream of the backprop block.
// Define WB_UPD_SAT_EN to saturate parameter updates; by default they wrap.
module wb_update #(
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_HL_P = 3,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned FRAC   = 24,
    parameter int unsigned BATCH  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_smpl_vld,
    output logic                                  o_ready,
    output logic                                  o_accu,
    output logic                                  o_rst_btch,
    input  logic [N_OUT*WIDTH-1:0]                i_d_bias_o,
    input  logic [N_HL_P*WIDTH-1:0]               i_d_bias_hd,
    input  logic [N_HL_P*N_OUT*WIDTH-1:0]         i_d_wght_o,
    input  logic [N_HL_P*N_IN*WIDTH-1:0]          i_d_wght_hd,
    input  logic                                  i_ld,
    input  logic [(N_OUT + N_HL_P + N_HL_P*N_OUT + N_HL_P*N_IN)*WIDTH-1:0] i_ld_par,
    output logic [N_OUT*WIDTH-1:0]                o_bias_o,
    output logic [N_HL_P*WIDTH-1:0]               o_bias_hd,
    output logic [N_HL_P*N_OUT*WIDTH-1:0]         o_wght_o,
    output logic [N_HL_P*N_IN*WIDTH-1:0]          o_wght_hd,
    output logic                                  o_busy,
    output logic                                  o_upd_done,
    output logic [15:0]                           o_n_upd
);

    localparam int unsigned N_PAR   = N_OUT + N_HL_P + N_HL_P*N_OUT + N_HL_P*N_IN;
    localparam int unsigned KW      = (N_PAR > 1) ? $clog2(N_PAR) : 1;
    localparam int unsigned SCW     = (BATCH > 1) ? $clog2(BATCH) : 1;
    localparam int unsigned OFF_BHD = N_OUT * WIDTH;
    localparam int unsigned OFF_WO  = OFF_BHD + N_HL_P * WIDTH;
    localparam int unsigned OFF_WHD = OFF_WO + N_HL_P * N_OUT * WIDTH;
    localparam logic [KW-1:0]  K_LAST  = KW'(N_PAR - 1);
    localparam logic [SCW-1:0] S_LAST  = SCW'(BATCH - 1);

    if (BATCH < 1 || FRAC >= WIDTH) begin : g_param_check
        $error("wb_update: BATCH must be >= 1 and FRAC < WIDTH");
    end

    typedef enum logic [1:0] {StClr, StAcc, StUpd} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     par_q [N_PAR];
    logic [KW-1:0]        k_q;
    logic [SCW-1:0]       smpl_cnt_q;
    logic [15:0]          n_upd_q;
    logic                 upd_done_q;

    logic [N_PAR*WIDTH-1:0] d_flat;
    logic [N_PAR*WIDTH-1:0] par_flat;
    logic [WIDTH-1:0]     p_sel;
    logic [WIDTH-1:0]     d_sel;
    logic [WIDTH-1:0]     upd_word;
    logic                 smpl_acc;
    logic                 batch_last;
    logic                 upd_last;

    // Delta words share the parameter index order: bias_o, bias_hd, wght_o, wght_hd.
    assign d_flat     = {i_d_wght_hd, i_d_wght_o, i_d_bias_hd, i_d_bias_o};
    assign smpl_acc   = (state_q == StAcc) && i_smpl_vld;
    assign batch_last = smpl_acc && (smpl_cnt_q == S_LAST);
    assign upd_last   = (state_q == StUpd) && (k_q == K_LAST);

    assign p_sel = par_q[k_q];
    assign d_sel = d_flat[int'(k_q)*WIDTH +: WIDTH];

`ifdef WB_UPD_SAT_EN
    logic [WIDTH:0] diff;

    always_comb begin
        diff = {p_sel[WIDTH-1], p_sel} - {d_sel[WIDTH-1], d_sel};
        if (diff[WIDTH] != diff[WIDTH-1]) begin
            upd_word = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            upd_word = diff[WIDTH-1:0];
        end
    end
`else
    assign upd_word = p_sel - d_sel;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClr;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a load restarts the batch from CLR in every state.
    always_comb begin
        state_d = state_q;
        if (i_ld) begin
            state_d = StClr;
        end else begin
            unique case (state_q)
                StClr:   state_d = StAcc;
                StAcc:   if (batch_last) state_d = StUpd;
                StUpd:   if (upd_last) state_d = StClr;
                default: state_d = StClr;
            endcase
        end
    end

    // Output decode
    always_comb begin
        o_rst_btch = 1'b0;
        o_ready    = 1'b0;
        o_accu     = 1'b0;
        o_busy     = 1'b0;
        unique case (state_q)
            StClr: o_rst_btch = 1'b1;
            StAcc: begin
                o_ready = 1'b1;
                o_accu  = i_smpl_vld;
            end
            StUpd: o_busy = 1'b1;
            default: o_rst_btch = 1'b1;
        endcase
    end

    // Parameter store, counters and completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_PAR; k++) begin
                par_q[k] <= '0;
            end
            k_q        <= '0;
            smpl_cnt_q <= '0;
            n_upd_q    <= '0;
            upd_done_q <= 1'b0;
        end else if (i_ld) begin
            for (int k = 0; k < N_PAR; k++) begin
                par_q[k] <= i_ld_par[k*WIDTH +: WIDTH];
            end
            k_q        <= '0;
            smpl_cnt_q <= '0;
            upd_done_q <= 1'b0;
        end else begin
            upd_done_q <= upd_last;
            if (smpl_acc) begin
                smpl_cnt_q <= batch_last ? '0 : smpl_cnt_q + 1'b1;
            end
            if (state_q == StUpd) begin
                par_q[k_q] <= upd_word;
                k_q        <= upd_last ? '0 : k_q + 1'b1;
                if (upd_last) begin
                    n_upd_q <= n_upd_q + 16'd1;
                end
            end
        end
    end

    always_comb begin
        par_flat = '0;
        for (int k = 0; k < N_PAR; k++) begin
            par_flat[k*WIDTH +: WIDTH] = par_q[k];
        end
    end

    assign o_bias_o   = par_flat[0 +: N_OUT*WIDTH];
    assign o_bias_hd  = par_flat[OFF_BHD +: N_HL_P*WIDTH];
    assign o_wght_o   = par_flat[OFF_WO +: N_HL_P*N_OUT*WIDTH];
    assign o_wght_hd  = par_flat[OFF_WHD +: N_HL_P*N_IN*WIDTH];
    assign o_upd_done = upd_done_q;
    assign o_n_upd    = n_upd_q;

endmodule

// File: tb/tb_wb_update.sv
// tb_wb_update: directed self-checking bench for wb_update at default parameters.
// Honours WB_UPD_SAT_EN the same way the design does.
module tb_wb_update;

    localparam int N_IN   = 2;
    localparam int N_HL_P = 3;
    localparam int N_OUT  = 2;
    localparam int WIDTH  = 32;
    localparam int BATCH  = 4;
    localparam int N_PAR  = 17;
    localparam int PW     = N_PAR * WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_smpl_vld = 1'b0;
    logic i_ld = 1'b0;
    logic o_ready, o_accu, o_rst_btch, o_busy, o_upd_done;
    logic [15:0] o_n_upd;
    logic [N_OUT*WIDTH-1:0]        i_d_bias_o, o_bias_o;
    logic [N_HL_P*WIDTH-1:0]       i_d_bias_hd, o_bias_hd;
    logic [N_HL_P*N_OUT*WIDTH-1:0] i_d_wght_o, o_wght_o;
    logic [N_HL_P*N_IN*WIDTH-1:0]  i_d_wght_hd, o_wght_hd;
    logic [PW-1:0] i_ld_par = '0;
    logic [PW-1:0] d_img = '0;
    logic [PW-1:0] dut_img;
    logic [PW-1:0] model = '0;
    logic [PW-1:0] img_b;
    logic [PW-1:0] exp_q [$];

    int checks = 0;
    int failures = 0;

    assign {i_d_wght_hd, i_d_wght_o, i_d_bias_hd, i_d_bias_o} = d_img;
    assign dut_img = {o_wght_hd, o_wght_o, o_bias_hd, o_bias_o};

    always #5 clk = ~clk;

    wb_update dut (
        .clk        (clk),
        .rst        (rst),
        .i_smpl_vld (i_smpl_vld),
        .o_ready    (o_ready),
        .o_accu     (o_accu),
        .o_rst_btch (o_rst_btch),
        .i_d_bias_o (i_d_bias_o),
        .i_d_bias_hd(i_d_bias_hd),
        .i_d_wght_o (i_d_wght_o),
        .i_d_wght_hd(i_d_wght_hd),
        .i_ld       (i_ld),
        .i_ld_par   (i_ld_par),
        .o_bias_o   (o_bias_o),
        .o_bias_hd  (o_bias_hd),
        .o_wght_o   (o_wght_o),
        .o_wght_hd  (o_wght_hd),
        .o_busy     (o_busy),
        .o_upd_done (o_upd_done),
        .o_n_upd    (o_n_upd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_img(input string tag, input logic [PW-1:0] e);
        for (int k = 0; k < N_PAR; k++) begin
            check($sformatf("%s[%0d]", tag, k), dut_img[k*WIDTH +: WIDTH], e[k*WIDTH +: WIDTH]);
        end
    endtask

    function automatic logic [PW-1:0] fill(input logic [31:0] w);
        logic [PW-1:0] r;
        for (int k = 0; k < N_PAR; k++) r[k*WIDTH +: WIDTH] = w;
        return r;
    endfunction

    // Reference update using 64-bit integer arithmetic.
    function automatic logic [PW-1:0] apply_upd(input logic [PW-1:0] p, input logic [PW-1:0] d);
        logic [PW-1:0] r;
        longint s;
        for (int k = 0; k < N_PAR; k++) begin
            s = longint'($signed(p[k*WIDTH +: WIDTH])) - longint'($signed(d[k*WIDTH +: WIDTH]));
`ifdef WB_UPD_SAT_EN
            if (s > 64'sd2147483647)       r[k*WIDTH +: WIDTH] = 32'h7FFF_FFFF;
            else if (s < -64'sd2147483648) r[k*WIDTH +: WIDTH] = 32'h8000_0000;
            else                           r[k*WIDTH +: WIDTH] = s[31:0];
`else
            r[k*WIDTH +: WIDTH] = s[31:0];
`endif
        end
        return r;
    endfunction

    task automatic load(input logic [PW-1:0] img);
        @(negedge clk);
        i_smpl_vld = 1'b0;
        i_ld = 1'b1;
        i_ld_par = img;
        @(negedge clk);
        i_ld = 1'b0;
        model = img;
    endtask

    task automatic run_batch(input bit push);
        for (int c = 0; c < BATCH; c++) begin
            @(negedge clk);
            i_smpl_vld = 1'b1;
        end
        if (push) exp_q.push_back(apply_upd(model, d_img));
    endtask

    // Waits (bounded) for o_upd_done, counting UPD cycles and any o_accu seen during UPD.
    task automatic finish_update(input string tag);
        int busy_cyc = 0;
        int accu_upd = 0;
        bit found = 0;
        logic [PW-1:0] e;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (o_busy) begin
                busy_cyc++;
                if (o_accu) accu_upd++;
            end
            if (o_upd_done) found = 1;
        end
        check({tag, "_done_seen"}, 32'(found), 32'd1);
        check({tag, "_upd_cycles"}, busy_cyc, N_PAR);
        check({tag, "_accu_in_upd"}, accu_upd, 0);
        check({tag, "_rst_btch"}, 32'(o_rst_btch), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_img({tag, "_par"}, e);
            model = e;
        end else begin
            check({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end
        i_smpl_vld = 1'b0;
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(o_ready), 32'd1);
        check({tag, "_done_one_cycle"}, 32'(o_upd_done), 32'd0);
    endtask

    initial begin
        int accu_cnt;
        int busy_cnt;
        bit hit;
        logic [PW-1:0] img;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rst_btch", 32'(o_rst_btch), 32'd1);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_upd_done", 32'(o_upd_done), 32'd0);
        check("rst_n_upd", 32'(o_n_upd), 32'd0);
        check_img("rst_par", '0);
        rst = 1'b0;
        #1;
        check("rel_rst_btch", 32'(o_rst_btch), 32'd1);
        @(negedge clk);
        check("rel_ready", 32'(o_ready), 32'd1);
        check("rel_rst_btch_low", 32'(o_rst_btch), 32'd0);

        // Load 1.0 everywhere, then a gapped batch of 0.25 deltas
        load(fill(32'h0100_0000));
        check("ld_rst_btch", 32'(o_rst_btch), 32'd1);
        check_img("ld_par", model);
        d_img = fill(32'h0040_0000);
        accu_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            i_smpl_vld = (c == 0 || c == 3 || c == 4 || c == 9);
            if (c == 9) exp_q.push_back(apply_upd(model, d_img));
            #1;
            if (o_accu) accu_cnt++;
        end
        check("gap_accu_cnt", accu_cnt, 4);
        finish_update("gap");
        check("gap_word0", dut_img[31:0], 32'h00C0_0000);
        check("gap_word16", dut_img[16*WIDTH +: WIDTH], 32'h00C0_0000);
        check("gap_n_upd", 32'(o_n_upd), 32'd1);

        // Overflow behaviour at both signed limits
        img = '0;
        for (int k = 0; k < N_PAR; k++) img[k*WIDTH +: WIDTH] = $urandom;
        img[31:0]  = 32'h8000_0000;
        img[63:32] = 32'h7FFF_FFFF;
        load(img);
        for (int k = 0; k < N_PAR; k++) d_img[k*WIDTH +: WIDTH] = $urandom;
        d_img[31:0]  = 32'h0000_0001;
        d_img[63:32] = 32'hFFFF_FFFF;
        @(negedge clk);
        run_batch(1);
        finish_update("ovf");
`ifdef WB_UPD_SAT_EN
        check("ovf_neg_limit", dut_img[31:0], 32'h8000_0000);
        check("ovf_pos_limit", dut_img[63:32], 32'h7FFF_FFFF);
`else
        check("ovf_neg_limit", dut_img[31:0], 32'h7FFF_FFFF);
        check("ovf_pos_limit", dut_img[63:32], 32'h8000_0000);
`endif
        check("ovf_n_upd", 32'(o_n_upd), 32'd2);

        // Abort an update at k=5 with a load
        for (int k = 0; k < N_PAR; k++) img_b[k*WIDTH +: WIDTH] = $urandom;
        run_batch(0);
        busy_cnt = 0;
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (o_busy) busy_cnt++;
            if (busy_cnt == 6) begin
                hit = 1;
                i_smpl_vld = 1'b0;
                i_ld = 1'b1;
                i_ld_par = img_b;
            end
        end
        check("abort_reached_k5", 32'(hit), 32'd1);
        @(negedge clk);
        i_ld = 1'b0;
        model = img_b;
        check_img("abort_par", img_b);
        check("abort_no_done", 32'(o_upd_done), 32'd0);
        check("abort_n_upd", 32'(o_n_upd), 32'd2);
        check("abort_rst_btch", 32'(o_rst_btch), 32'd1);
        check("abort_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        check("abort_ready", 32'(o_ready), 32'd1);
        check("abort_no_done_late", 32'(o_upd_done), 32'd0);

        // Asynchronous reset in the middle of an update
        run_batch(0);
        repeat (4) @(negedge clk);
        check("arst_busy_before", 32'(o_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_img("arst_par", '0);
        check("arst_rst_btch", 32'(o_rst_btch), 32'd1);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_n_upd", 32'(o_n_upd), 32'd0);
        @(negedge clk);
        i_smpl_vld = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_rel_rst_btch", 32'(o_rst_btch), 32'd1);
        @(negedge clk);
        check("arst_rel_ready", 32'(o_ready), 32'd1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
